// File: rtl/jtgng_snd_pkg.sv
// Shared constants for the main/sound CPU glue: status register layout and
// parameter limits, plus a helper that packs the status byte.
// Purely combinational; no state, no flow control.
package jtgng_snd_pkg;

    localparam int PEND_LSB    = 0;
    localparam int REPLY_BIT   = 3;
    localparam int OVR_LSB     = 4;
    localparam int MAX_LATCHES = 4;
    localparam int MAX_WAITS   = 7;

    // Status byte: pending flags from bit 0 up, overrun flags from bit 4 up,
    // reply-pending at bit 3. With four latches pend[3] shares bit 3 with the
    // reply flag, so the two are ORed there.
    function automatic logic [7:0] pack_status(
        input logic [3:0] pend,
        input logic [3:0] ovr,
        input logic       reply_pend
    );
        logic [7:0] s;
        s                  = 8'h00;
        s[PEND_LSB +: 4]   = pend;
        s[OVR_LSB  +: 4]   = ovr;
        s[REPLY_BIT]       = s[REPLY_BIT] | reply_pend;
        return s;
    endfunction

endpackage

// File: rtl/jtgng_snd_latch.sv
// One 8-bit mailbox: data register, pending flag and overrun flag.
// Latency: data and flags update one clk after the strobe.
// No backpressure: a write always lands; a write in the same clk as a read keeps pend set.
//
// Ports: clk, rst (sync, active high), wr (store din, set pend),
//        rd (clear pend), ovr_clr (clear ovr), din, dat, pend, ovr.
module jtgng_snd_latch
    import jtgng_snd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       rd,
    input  logic       ovr_clr,
    input  logic [7:0] din,
    output logic [7:0] dat,
    output logic       pend,
    output logic       ovr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dat  <= 8'h00;
            pend <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (wr) begin
                dat  <= din;
                pend <= 1'b1;
            end else if (rd) begin
                pend <= 1'b0;
            end
            // Writing over an unread value flags an overrun; that beats a
            // simultaneous status-read clear so the loss is never hidden.
            if (wr && pend)
                ovr <= 1'b1;
            else if (ovr_clr)
                ovr <= 1'b0;
        end
    end

endmodule

// File: rtl/jtgng_snd_glue.sv
// Main-CPU / Z80 sound-CPU glue: reset stretcher, command latches, IRQ, FM wait states, reply latch.
// Latency: latches/flags/int_n one clk after the strobe; snd_din and wait_n are combinational.
// No backpressure on the main side; the sound CPU is stalled only through wait_n on FM accesses.
//
// Ports: clk/rst (sync, active high), cen3/main_cen clock enables, sres_b sound reset from main,
//        main_dout/main_latch_cs main writes, main_reply/reply_pend/main_reply_rd reply path,
//        snd_int periodic IRQ, snd_rst_n, Z80 strobes iorq_n/rd_n/wr_n, decodes latch_rd/stat_rd/
//        reply_wr/fm_cs, snd_dout Z80 write data, snd_din read mux, int_n, wait_n.
// Build option: JTGNG_SNDGLUE_REPLY_EN implements the sound-to-main reply latch.
module jtgng_snd_glue
    import jtgng_snd_pkg::*;
#(
    parameter int LATCHES   = 1,
    parameter int RSTW      = 4,
    parameter int WAITS     = 2,
    parameter int LATCH_INT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen3,
    input  logic               main_cen,
    input  logic               sres_b,
    input  logic [7:0]         main_dout,
    input  logic [LATCHES-1:0] main_latch_cs,
    output logic [7:0]         main_reply,
    output logic               reply_pend,
    input  logic               main_reply_rd,
    input  logic               snd_int,
    output logic               snd_rst_n,
    input  logic               iorq_n,
    input  logic               rd_n,
    input  logic               wr_n,
    input  logic [LATCHES-1:0] latch_rd,
    input  logic               stat_rd,
    input  logic               reply_wr,
    input  logic               fm_cs,
    input  logic [7:0]         snd_dout,
    output logic [7:0]         snd_din,
    output logic               int_n,
    output logic               wait_n
);

    // ---------------- local reset stretcher ----------------
    logic [RSTW-1:0] rst_cnt;

    always_ff @(posedge clk) begin
        if (rst || !sres_b) begin
            rst_cnt   <= '0;
            snd_rst_n <= 1'b0;
        end else begin
            if (rst_cnt != '1)
                rst_cnt <= rst_cnt + 1'b1;
            // Counter saturates, so release is sticky until the next reset.
            snd_rst_n <= &rst_cnt;
        end
    end

    // The raw reset terms are included so a sres_b drop clears the sound-side
    // state on the very next clk, not one clk later via snd_rst_n.
    logic blk_rst;
    assign blk_rst = rst | ~sres_b | ~snd_rst_n;

    // ---------------- main-to-sound latches ----------------
    logic             rd_cyc;
    logic [LATCHES-1:0] pend;
    logic [LATCHES-1:0] ovr;
    logic [7:0]       latch_dat [LATCHES];

    assign rd_cyc = cen3 & ~rd_n;

    genvar gi;
    generate
        for (gi = 0; gi < LATCHES; gi++) begin : g_latch
            jtgng_snd_latch u_latch (
                .clk     (clk),
                .rst     (blk_rst),
                .wr      (main_cen & main_latch_cs[gi]),
                .rd      (rd_cyc & latch_rd[gi]),
                .ovr_clr (rd_cyc & stat_rd),
                .din     (main_dout),
                .dat     (latch_dat[gi]),
                .pend    (pend[gi]),
                .ovr     (ovr[gi])
            );
        end
    endgenerate

    // ---------------- sound-to-main reply ----------------
`ifdef JTGNG_SNDGLUE_REPLY_EN
    logic reply_ovr_unused;

    jtgng_snd_latch u_reply (
        .clk     (clk),
        .rst     (blk_rst),
        .wr      (cen3 & ~wr_n & reply_wr),
        .rd      (main_cen & main_reply_rd),
        .ovr_clr (1'b0),
        .din     (snd_dout),
        .dat     (main_reply),
        .pend    (reply_pend),
        .ovr     (reply_ovr_unused)
    );
`else
    logic unused_reply;

    assign main_reply   = 8'h00;
    assign reply_pend   = 1'b0;
    assign unused_reply = &{1'b0, reply_wr, main_reply_rd, wr_n, snd_dout};
`endif

    // ---------------- sound data mux ----------------
    always_comb begin
        snd_din = 8'h00;
        if (|latch_rd) begin
            for (int i = 0; i < LATCHES; i++)
                if (latch_rd[i])
                    snd_din = snd_din | latch_dat[i];
        end else if (stat_rd) begin
            snd_din = pack_status(4'(pend), 4'(ovr), reply_pend);
        end
    end

    // ---------------- interrupt ----------------
    logic int_l;
    logic int_req;

    assign int_req = (cen3 & snd_int & ~int_l)
                   | ((LATCH_INT != 0) & main_cen & main_latch_cs[0]);

    always_ff @(posedge clk) begin
        if (blk_rst) begin
            int_n <= 1'b1;
            int_l <= 1'b0;
        end else begin
            if (cen3)
                int_l <= snd_int;
            if (cen3 && !iorq_n)
                int_n <= 1'b1;          // acknowledge beats a new request
            else if (int_req)
                int_n <= 1'b0;
        end
    end

    // ---------------- FM wait states ----------------
    // The first cen3 period of an access is covered combinationally by
    // fm_start; wcnt covers the remaining WAITS-1 periods.
    localparam logic [2:0] WLOAD = 3'(WAITS > 0 ? WAITS - 1 : 0);

    logic       fm_l;
    logic       fm_start;
    logic [2:0] wcnt;

    assign fm_start = fm_cs & ~fm_l;

    always_ff @(posedge clk) begin
        if (blk_rst) begin
            fm_l <= 1'b0;
            wcnt <= 3'd0;
        end else if (cen3) begin
            fm_l <= fm_cs;
            if (fm_start)
                wcnt <= WLOAD;
            else if (wcnt != 3'd0)
                wcnt <= wcnt - 1'b1;
        end
    end

    assign wait_n = (WAITS == 0) | ~snd_rst_n | (~fm_start & (wcnt == 3'd0));

endmodule

// File: tb/tb_jtgng_snd_glue.sv
module tb_jtgng_snd_glue;

    localparam int LATCHES = 2;
    localparam int RSTW    = 4;
    localparam int WAITS   = 2;

    logic       clk;
    logic       rst, cen3, main_cen, sres_b;
    logic [7:0] main_dout;
    logic [1:0] main_latch_cs;
    logic [7:0] main_reply;
    logic       reply_pend, main_reply_rd, snd_int, snd_rst_n;
    logic       iorq_n, rd_n, wr_n;
    logic [1:0] latch_rd;
    logic       stat_rd, reply_wr, fm_cs;
    logic [7:0] snd_dout, snd_din;
    logic       int_n, wait_n;

    int n_cmp = 0;
    int n_bad = 0;

    jtgng_snd_glue #(
        .LATCHES(LATCHES), .RSTW(RSTW), .WAITS(WAITS), .LATCH_INT(1)
    ) dut (
        .clk(clk), .rst(rst), .cen3(cen3), .main_cen(main_cen), .sres_b(sres_b),
        .main_dout(main_dout), .main_latch_cs(main_latch_cs),
        .main_reply(main_reply), .reply_pend(reply_pend), .main_reply_rd(main_reply_rd),
        .snd_int(snd_int), .snd_rst_n(snd_rst_n),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .latch_rd(latch_rd), .stat_rd(stat_rd), .reply_wr(reply_wr), .fm_cs(fm_cs),
        .snd_dout(snd_dout), .snd_din(snd_din), .int_n(int_n), .wait_n(wait_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    bit         m_valid = 0;
    int         m_rel   = 0;     // clks since local reset released
    bit         m_srn   = 0;
    logic [7:0] m_lat [2];
    bit         m_pend [2];
    bit         m_ovr  [2];
    bit         m_intn  = 1;
    bit         m_sint  = 0;     // last snd_int seen on a cen3
    bit         m_fmp   = 0;     // last fm_cs seen on a cen3
    int         m_wleft = 0;     // further cen3 periods still to wait
    logic [7:0] m_rep   = 8'h00;
    bit         m_rpend = 0;

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 2; i++) begin
            if (m_pend[i]) s = s + (8'd1 << i);
            if (m_ovr[i])  s = s + (8'd16 << i);
        end
        if (m_rpend) s = s + 8'd8;
        return s;
    endfunction

    function automatic logic [7:0] m_din();
        if (latch_rd == 2'b01) return m_lat[0];
        if (latch_rd == 2'b10) return m_lat[1];
        if (latch_rd == 2'b11) return m_lat[0] | m_lat[1];
        if (stat_rd)           return m_status();
        return 8'h00;
    endfunction

    task automatic model_check();
        bit exp_wait;
        if (!m_valid) return;
        exp_wait = !m_srn || !((fm_cs && !m_fmp) || m_wleft > 0);
        cmp("snd_rst_n",  {7'd0, snd_rst_n},  {7'd0, m_srn});
        cmp("int_n",      {7'd0, int_n},      {7'd0, m_intn});
        cmp("wait_n",     {7'd0, wait_n},     {7'd0, exp_wait});
        cmp("snd_din",    snd_din,            m_din());
        cmp("main_reply", main_reply,         m_rep);
        cmp("reply_pend", {7'd0, reply_pend}, {7'd0, m_rpend});
    endtask

    task automatic model_update();
        bit blk, wr, stclr, rdclr;
        blk = rst || !sres_b || !m_srn;
        if (rst || !sres_b) begin
            m_rel = 0;
            m_srn = 0;
        end else begin
            if (m_rel < 100000) m_rel++;
            m_srn = (m_rel >= (1 << RSTW));
        end
        if (rst) m_valid = 1;
        if (blk) begin
            for (int i = 0; i < 2; i++) begin
                m_lat[i] = 8'h00; m_pend[i] = 0; m_ovr[i] = 0;
            end
            m_intn = 1; m_sint = 0; m_fmp = 0; m_wleft = 0;
            m_rep = 8'h00; m_rpend = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr    = main_cen && main_latch_cs[i];
                stclr = cen3 && !rd_n && stat_rd;
                rdclr = cen3 && !rd_n && latch_rd[i];
                if (wr && m_pend[i]) m_ovr[i] = 1;
                else if (stclr)      m_ovr[i] = 0;
                if (wr) begin
                    m_lat[i]  = main_dout;
                    m_pend[i] = 1;
                end else if (rdclr) begin
                    m_pend[i] = 0;
                end
            end
            if (cen3 && !iorq_n)
                m_intn = 1;
            else if ((cen3 && snd_int && !m_sint) || (main_cen && main_latch_cs[0]))
                m_intn = 0;
            if (cen3) begin
                m_sint = snd_int;
                if (fm_cs && !m_fmp) m_wleft = WAITS - 1;
                else if (m_wleft > 0) m_wleft--;
                m_fmp = fm_cs;
            end
`ifdef JTGNG_SNDGLUE_REPLY_EN
            if (cen3 && !wr_n && reply_wr) begin
                m_rep   = snd_dout;
                m_rpend = 1;
            end else if (main_cen && main_reply_rd) begin
                m_rpend = 0;
            end
`endif
        end
    endtask

    // One clock: check outputs for the inputs already applied, advance, return at negedge.
    task automatic cyc();
        #1 model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; cen3 = 0; main_cen = 0; sres_b = 1; main_dout = 8'h00;
        main_latch_cs = 2'b00; main_reply_rd = 0; iorq_n = 1; rd_n = 1; wr_n = 1;
        latch_rd = 2'b00; stat_rd = 0; reply_wr = 0; snd_dout = 8'h00;
    endtask

    task automatic wait_release(input string name);
        int n;
        n = 0;
        while (!snd_rst_n && n < 40) begin
            cyc();
            n++;
        end
        cmp(name, 8'(n), 8'd16);
    endtask

    initial begin
        int low;
        int sel;
        idle();
        snd_int = 0;
        fm_cs   = 0;

        // reset and release timing
        rst = 1;
        cyc();
        rst = 0; stat_rd = 1;
        #1;
        cmp("rst snd_rst_n", {7'd0, snd_rst_n}, 8'd0);
        cmp("rst int_n",     {7'd0, int_n},     8'd1);
        cmp("rst wait_n",    {7'd0, wait_n},    8'd1);
        cmp("rst status",    snd_din,           8'h00);
        cmp("rst reply",     main_reply,        8'h00);
        wait_release("release clks");

        // latch 1 write, then sound read
        idle();
        main_cen = 1; main_latch_cs = 2'b10; main_dout = 8'h5A;
        cyc();
        idle(); stat_rd = 1; #1;
        cmp("status pend1", snd_din, 8'h02);
        idle(); latch_rd = 2'b10; #1;
        cmp("latch1 data", snd_din, 8'h5A);
        cen3 = 1; rd_n = 0;
        cyc();
        idle(); stat_rd = 1; #1;
        cmp("status after read", snd_din, 8'h00);

        // overrun on latch 0, status read clears ovr
        idle(); main_cen = 1; main_latch_cs = 2'b01; main_dout = 8'h11;
        cyc();
        main_dout = 8'h22;
        cyc();
        idle(); stat_rd = 1; #1;
        cmp("status ovr", snd_din, 8'h11);
        cmp("latch int", {7'd0, int_n}, 8'd0);
        cen3 = 1; rd_n = 0;
        cyc();
        idle(); stat_rd = 1; #1;
        cmp("status ovr clr", snd_din, 8'h01);
        idle(); cen3 = 1; iorq_n = 0;
        cyc();
        idle(); #1;
        cmp("ack", {7'd0, int_n}, 8'd1);

        // periodic interrupt edge and ack priority
        snd_int = 1; cen3 = 1;
        cyc();
        cmp("snd_int edge", {7'd0, int_n}, 8'd0);
        snd_int = 0;
        cyc();
        snd_int = 1; iorq_n = 0;
        cyc();
        cmp("ack wins", {7'd0, int_n}, 8'd1);
        idle();

        // FM wait: cen3 every third clk, fm_cs held for four cen3
        fm_cs = 1;
        low = 0;
        for (int k = 0; k < 12; k++) begin
            cen3 = (k % 3 == 2);
            #1;
            if (k == 0) cmp("wait first", {7'd0, wait_n}, 8'd0);
            if (!wait_n) low++;
            cyc();
        end
        cmp("wait clks", 8'(low), 8'(3 * WAITS));
        fm_cs = 0; cen3 = 1;
        cyc();
        idle();

        // reply latch
        cen3 = 1; wr_n = 0; reply_wr = 1; snd_dout = 8'hC3;
        cyc();
        idle(); stat_rd = 1; #1;
`ifdef JTGNG_SNDGLUE_REPLY_EN
        cmp("reply data",   main_reply,        8'hC3);
        cmp("reply pend",   {7'd0, reply_pend}, 8'd1);
        cmp("status reply", snd_din,           8'h09);
`else
        cmp("reply data",   main_reply,        8'h00);
        cmp("reply pend",   {7'd0, reply_pend}, 8'd0);
        cmp("status reply", snd_din,           8'h01);
`endif
        idle(); main_cen = 1; main_reply_rd = 1;
        cyc();
        idle(); #1;
        cmp("reply read", {7'd0, reply_pend}, 8'd0);

        // mid-run sound reset
        main_cen = 1; main_latch_cs = 2'b01; main_dout = 8'h77;
        cyc();
        idle(); sres_b = 0;
        cyc();
        stat_rd = 1; #1;
        cmp("sres snd_rst_n", {7'd0, snd_rst_n}, 8'd0);
        cmp("sres int_n",     {7'd0, int_n},     8'd1);
        cmp("sres status",    snd_din,           8'h00);
        sres_b = 1;
        wait_release("sres release clks");

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst           = ($urandom_range(0, 599) == 0);
            sres_b        = ($urandom_range(0, 399) != 0);
            cen3          = ($urandom_range(0, 3) == 0);
            main_cen      = 1'($urandom_range(0, 1));
            sel           = $urandom_range(0, 5);
            main_latch_cs = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b10 : 2'b00;
            main_dout     = 8'($urandom);
            rd_n          = 1'($urandom_range(0, 1));
            wr_n          = 1'($urandom_range(0, 1));
            iorq_n        = ($urandom_range(0, 7) != 0);
            sel           = $urandom_range(0, 3);
            latch_rd      = (sel == 1) ? 2'b01 : (sel == 2) ? 2'b10 : 2'b00;
            stat_rd       = (sel == 3);
            reply_wr      = ($urandom_range(0, 3) == 0);
            main_reply_rd = ($urandom_range(0, 3) == 0);
            snd_dout      = 8'($urandom);
            if ($urandom_range(0, 9) == 0)  fm_cs   = ~fm_cs;
            if ($urandom_range(0, 15) == 0) snd_int = ~snd_int;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
